combo_lock_ctrl: RTL and testbench

Clocked, parametrised combination-lock controller driving six active-low 7-segment digits (led5 = leftmost).
- Compares a CODE_W-bit attempt against a stored code on each submit rising edge.
- Tracks remaining tries and enters a timed lockout with a visible seconds countdown.
- Sits between board switches/buttons and the HEX displays.
- Supersedes the unclocked single-width lock with a real FSM, edge-detected submit, lockout recovery and parametrised widths and timings.

---
 rtl/combo_lock_pkg.sv | 31 +++
 rtl/combo_lock_if.sv | 31 +++
 rtl/combo_lock_ctrl_seg7.sv | 12 +
 rtl/combo_lock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and 7-segment glyphs for the combination-lock controller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    ARMED   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_Y     = 7'h11;
  localparam logic [6:0] SEG_EQ    = 7'h37;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_N     = 7'h48;
  localparam logic [6:0] SEG_I     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] DIGIT_GLYPH [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/combo_lock_if.sv
// Switch/button inputs and display/status outputs of the combination lock.
interface combo_lock_if #(
  parameter int unsigned CODE_W    = 8,
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  logic              en;
  logic              submit;
  logic              prog;
  logic [CODE_W-1:0] passcode_attempt;
  logic [6:0]        led0;
  logic [6:0]        led1;
  logic [6:0]        led2;
  logic [6:0]        led3;
  logic [6:0]        led4;
  logic [6:0]        led5;
  logic              unlocked;
  logic              locked_out;
  logic [TRY_W-1:0]  tries_left;

  modport master (
    output en, submit, prog, passcode_attempt,
    input  led0, led1, led2, led3, led4, led5, unlocked, locked_out, tries_left
  );

  modport slave (
    input  en, submit, prog, passcode_attempt,
    output led0, led1, led2, led3, led4, led5, unlocked, locked_out, tries_left
  );
endinterface

// File: rtl/combo_lock_ctrl_seg7.sv
// Decimal digit to active-low 7-segment glyph; values above 9 show blank.
module seg7_digit
  import combo_lock_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg_c
);
  always_comb begin
    seg_c = SEG_BLANK;
    if (val <= 4'd9) seg_c = DIGIT_GLYPH[val];
  end
endmodule

// File: rtl/combo_lock_ctrl.sv
// Clocked combination-lock controller with tries tracking, timed lockout and
// six-digit display. Define COMBO_LOCK_CODE_PROG_EN to allow reprogramming in OPEN.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned       CODE_W        = 8,
  parameter logic [CODE_W-1:0] DEFAULT_CODE  = CODE_W'(8'h49),
  parameter int unsigned       MAX_TRIES     = 3,
  parameter int unsigned       LOCKOUT_SEC   = 5,
  parameter int unsigned       TICKS_PER_SEC = 50_000_000
) (
  input logic          clk,
  input logic          rst_n,
  combo_lock_if.slave  bus
);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned SEC_W  = 7;
  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [41:0] DISP_CLOSED = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_D};

  state_t            state_q, state_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              sub_q;
  logic              sub_edge;
  logic [5:0][6:0]   disp_q, disp_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_q, locked_d;
  logic [CODE_W-1:0] code_val;
  logic              flash_d;
  logic [6:0]        tries_seg_c, tens_seg_c, units_seg_c;

`ifdef COMBO_LOCK_CODE_PROG_EN
  logic [CODE_W-1:0] code_q, code_d;
  assign code_val = code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) code_q <= DEFAULT_CODE;
    else        code_q <= code_d;
  end
`else
  logic unused_prog;
  assign unused_prog = bus.prog;
  assign code_val    = DEFAULT_CODE;
  assign flash_d     = 1'b0;
`endif

  assign sub_edge = bus.submit & ~sub_q;

  // Next-state logic; en falling beats a coincident submit edge.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    sec_d   = sec_q;
    tick_d  = tick_q;
`ifdef COMBO_LOCK_CODE_PROG_EN
    code_d  = code_q;
    flash_d = 1'b0;
`endif
    case (state_q)
      CLOSED: if (bus.en) state_d = ARMED;
      ARMED: begin
        if (!bus.en) begin
          state_d = CLOSED;
        end else if (sub_edge) begin
          if (bus.passcode_attempt == code_val) begin
            state_d = OPEN;
            tries_d = TRY_W'(MAX_TRIES);
          end else if (tries_q == TRY_W'(1)) begin
            state_d = LOCKOUT;
            tries_d = '0;
            sec_d   = SEC_W'(LOCKOUT_SEC);
            tick_d  = '0;
          end else begin
            tries_d = tries_q - TRY_W'(1);
          end
        end
      end
      OPEN: begin
        if (!bus.en) state_d = CLOSED;
`ifdef COMBO_LOCK_CODE_PROG_EN
        else if (sub_edge && bus.prog) begin
          code_d  = bus.passcode_attempt;
          flash_d = 1'b1;
        end
`endif
        else if (sub_edge) state_d = ARMED;
      end
      LOCKOUT: begin
        if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
          tick_d = '0;
          if (sec_q == SEC_W'(1)) begin
            tries_d = TRY_W'(MAX_TRIES);
            state_d = bus.en ? ARMED : CLOSED;
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  seg7_digit u_tries (.val(4'(tries_d)),             .seg_c(tries_seg_c));
  seg7_digit u_tens  (.val(4'(sec_d / SEC_W'(10))),  .seg_c(tens_seg_c));
  seg7_digit u_units (.val(4'(sec_d % SEC_W'(10))),  .seg_c(units_seg_c));

  // Display/status decode from the next state so registered outputs track it.
  always_comb begin
    disp_d     = DISP_CLOSED;
    unlocked_d = 1'b0;
    locked_d   = 1'b0;
    case (state_d)
      CLOSED: disp_d = DISP_CLOSED;
      ARMED:  disp_d = {SEG_T, SEG_R, SEG_Y, SEG_S, SEG_EQ, tries_seg_c};
      OPEN: begin
        unlocked_d = 1'b1;
        if (flash_d) disp_d = {SEG_S, SEG_E, SEG_T, SEG_BLANK, SEG_BLANK, SEG_BLANK};
        else         disp_d = {SEG_O, SEG_P, SEG_E, SEG_N, SEG_BLANK, SEG_BLANK};
      end
      LOCKOUT: begin
        locked_d = 1'b1;
        disp_d   = {SEG_D, SEG_E, SEG_N, SEG_BLANK, tens_seg_c, units_seg_c};
      end
      default: disp_d = DISP_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      tries_q    <= TRY_W'(MAX_TRIES);
      sec_q      <= '0;
      tick_q     <= '0;
      sub_q      <= 1'b1;
      disp_q     <= DISP_CLOSED;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      sub_q      <= bus.submit;
      disp_q     <= disp_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.led0       = disp_q[0];
  assign bus.led1       = disp_q[1];
  assign bus.led2       = disp_q[2];
  assign bus.led3       = disp_q[3];
  assign bus.led4       = disp_q[4];
  assign bus.led5       = disp_q[5];
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_q;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with a 4-tick second.
module tb_combo_lock_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  combo_lock_if #(.CODE_W(8), .MAX_TRIES(3)) bus ();

  combo_lock_ctrl #(
    .CODE_W(8), .DEFAULT_CODE(8'h49), .MAX_TRIES(3),
    .LOCKOUT_SEC(5), .TICKS_PER_SEC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [41:0] D_CLOSED = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
  localparam logic [41:0] D_OPEN   = {7'h40, 7'h0C, 7'h06, 7'h48, 7'h7F, 7'h7F};
  localparam logic [41:0] D_SET    = {7'h12, 7'h06, 7'h07, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [34:0] D_TRYS   = {7'h07, 7'h2F, 7'h11, 7'h12, 7'h37};
  localparam logic [34:0] D_DEN    = {7'h21, 7'h06, 7'h48, 7'h7F, 7'h40};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] disp();
    return {bus.led5, bus.led4, bus.led3, bus.led2, bus.led1, bus.led0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle submit pulse with the given attempt.
  task automatic pulse(input logic [7:0] code);
    bus.passcode_attempt = code;
    bus.submit = 1'b1;
    step();
    bus.submit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.submit = 1'b1;
    bus.prog = 1'b0;
    bus.passcode_attempt = 8'h00;
    step();
    step();
    check_eq("rst_disp", 64'(disp()), 64'(D_CLOSED));
    check_eq("rst_tries", 64'(bus.tries_left), 64'd3);
    check_eq("rst_unlocked", 64'(bus.unlocked), 64'd0);
    check_eq("rst_locked", 64'(bus.locked_out), 64'd0);

    // Release with submit still held: no attempt taken.
    rst_n = 1'b1;
    step();
    check_eq("armed_disp", 64'(disp()), 64'({D_TRYS, 7'h30}));
    step();
    check_eq("held_no_attempt", 64'(bus.tries_left), 64'd3);
    bus.submit = 1'b0;
    step();

    // Correct code opens, next submit relocks.
    pulse(8'h49);
    check_eq("open_unlocked", 64'(bus.unlocked), 64'd1);
    check_eq("open_disp", 64'(disp()), 64'(D_OPEN));
    step();
    pulse(8'h49);
    check_eq("relock_disp", 64'(disp()), 64'({D_TRYS, 7'h30}));
    check_eq("relock_unlocked", 64'(bus.unlocked), 64'd0);
    step();

    // Wrong attempts; submit held 3 cycles counts once.
    bus.passcode_attempt = 8'h00;
    bus.submit = 1'b1;
    step();
    check_eq("wrong1_tries", 64'(bus.tries_left), 64'd2);
    check_eq("wrong1_led0", 64'(bus.led0), 64'h24);
    step();
    step();
    check_eq("held3_tries", 64'(bus.tries_left), 64'd2);
    bus.submit = 1'b0;
    step();
    pulse(8'h00);
    check_eq("wrong2_led0", 64'(bus.led0), 64'h79);
    check_eq("wrong2_tries", 64'(bus.tries_left), 64'd1);
    step();
    pulse(8'h00);
    check_eq("lock_flag", 64'(bus.locked_out), 64'd1);
    check_eq("lock_tries", 64'(bus.tries_left), 64'd0);
    check_eq("lock_disp", 64'(disp()), 64'({D_DEN, 7'h12}));

    // Lockout ignores en and correct-code submits; counts down for 20 clks total.
    for (int i = 1; i <= 19; i++) begin
      if (i == 1) bus.en = 1'b0;
      if (i == 2) begin
        bus.passcode_attempt = 8'h49;
        bus.submit = 1'b1;
      end
      step();
      if (i == 4)  check_eq("cnt_04", 64'(disp()), 64'({D_DEN, 7'h19}));
      if (i == 8)  check_eq("cnt_03", 64'(disp()), 64'({D_DEN, 7'h30}));
      if (i == 12) check_eq("cnt_02", 64'(disp()), 64'({D_DEN, 7'h24}));
      if (i == 16) check_eq("cnt_01", 64'(disp()), 64'({D_DEN, 7'h79}));
      if (i == 19) check_eq("lock_still", 64'(bus.locked_out), 64'd1);
    end
    step();
    check_eq("unlock_flag", 64'(bus.locked_out), 64'd0);
    check_eq("unlock_disp", 64'(disp()), 64'(D_CLOSED));
    check_eq("unlock_tries", 64'(bus.tries_left), 64'd3);
    check_eq("unlock_open", 64'(bus.unlocked), 64'd0);

    // en falling with a submit edge in ARMED discards the attempt.
    bus.submit = 1'b0;
    bus.en = 1'b1;
    step();
    bus.passcode_attempt = 8'h00;
    bus.submit = 1'b1;
    bus.en = 1'b0;
    step();
    check_eq("enprio_disp", 64'(disp()), 64'(D_CLOSED));
    check_eq("enprio_tries", 64'(bus.tries_left), 64'd3);

    // Toggling en keeps the tries count.
    bus.submit = 1'b0;
    bus.en = 1'b1;
    step();
    pulse(8'h00);
    bus.en = 1'b0;
    step();
    bus.en = 1'b1;
    step();
    check_eq("keep_tries", 64'(bus.tries_left), 64'd2);
    check_eq("keep_led0", 64'(bus.led0), 64'h24);
    pulse(8'h49);
    check_eq("refill_tries", 64'(bus.tries_left), 64'd3);

    // en falling with a submit edge in OPEN goes to CLOSED.
    bus.submit = 1'b1;
    bus.en = 1'b0;
    step();
    check_eq("open_enprio", 64'(disp()), 64'(D_CLOSED));
    bus.submit = 1'b0;
    bus.en = 1'b1;
    step();
    pulse(8'h49);
    check_eq("reopen", 64'(bus.unlocked), 64'd1);
    step();

`ifdef COMBO_LOCK_CODE_PROG_EN
    bus.prog = 1'b1;
    pulse(8'hA5);
    check_eq("prog_set_disp", 64'(disp()), 64'(D_SET));
    check_eq("prog_set_open", 64'(bus.unlocked), 64'd1);
    bus.prog = 1'b0;
    step();
    check_eq("prog_back_open", 64'(disp()), 64'(D_OPEN));
    pulse(8'h00);
    check_eq("prog_relock", 64'(bus.unlocked), 64'd0);
    step();
    pulse(8'h49);
    check_eq("prog_old_fails", 64'(bus.tries_left), 64'd2);
    step();
    pulse(8'hA5);
    check_eq("prog_new_opens", 64'(bus.unlocked), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    pulse(8'h49);
    check_eq("prog_rst_default", 64'(bus.unlocked), 64'd1);
`else
    bus.prog = 1'b1;
    pulse(8'hA5);
    check_eq("noprog_relock", 64'(bus.unlocked), 64'd0);
    bus.prog = 1'b0;
    step();
    pulse(8'hA5);
    check_eq("noprog_code_kept", 64'(bus.tries_left), 64'd2);
    step();
    pulse(8'h49);
    check_eq("noprog_default_opens", 64'(bus.unlocked), 64'd1);
`endif

    // Reset mid-lockout.
    bus.en = 1'b1;
    step();
    pulse(8'h49);
    step();
    pulse(8'h00);
    step();
    pulse(8'h00);
    step();
    pulse(8'h00);
    check_eq("relock_out", 64'(bus.locked_out), 64'd1);
    step();
    rst_n = 1'b0;
    step();
    check_eq("midrst_disp", 64'(disp()), 64'(D_CLOSED));
    check_eq("midrst_tries", 64'(bus.tries_left), 64'd3);
    check_eq("midrst_locked", 64'(bus.locked_out), 64'd0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
